// File: rtl/dff_pkg.sv
// rtl/dff_pkg.sv - shared defaults and sizing helpers for the dff delay line
package dff_pkg;

  localparam int DFF_WIDTH_DEFAULT = 1;
  localparam int DFF_DEPTH_DEFAULT = 4;
  localparam int DFF_WIDTH_MAX     = 64;
  localparam int DFF_DEPTH_MAX     = 32;

  // Occupancy must be able to represent every value from 0 up to DEPTH inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_stage.sv
// rtl/dff_stage.sv - one delay-line stage: data register plus its valid bit
module dff_stage
  import dff_pkg::*;
#(
  parameter int WIDTH = DFF_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // Flush only drops validity; the data register keeps its old contents.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (en) begin
      data_d  = d;
      valid_d = d_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q       = data_q;
  assign q_valid = valid_q;

endmodule

// File: rtl/dff_delay_line.sv
// rtl/dff_delay_line.sv - DEPTH-stage enabled delay line with per-stage valid,
// flush and a registered occupancy count
module dff_delay_line
  import dff_pkg::*;
#(
  parameter int WIDTH        = DFF_WIDTH_DEFAULT,
  parameter int DEPTH        = DFF_DEPTH_DEFAULT,
  parameter int MASK_INVALID = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              d,
  input  logic                          d_valid,
  input  logic                          en,
  input  logic                          flush,
  output logic [WIDTH-1:0]              q,
  output logic                          q_valid,
  output logic [occ_width(DEPTH)-1:0]   occupancy
);

  localparam int OCC_W = occ_width(DEPTH);

  if (WIDTH < 1 || WIDTH > DFF_WIDTH_MAX) begin : g_bad_width
    $fatal(1, "dff_delay_line: WIDTH %0d outside 1..%0d", WIDTH, DFF_WIDTH_MAX);
  end
  if (DEPTH < 1 || DEPTH > DFF_DEPTH_MAX) begin : g_bad_depth
    $fatal(1, "dff_delay_line: DEPTH %0d outside 1..%0d", DEPTH, DFF_DEPTH_MAX);
  end
  if (MASK_INVALID != 0 && MASK_INVALID != 1) begin : g_bad_mask
    $fatal(1, "dff_delay_line: MASK_INVALID %0d must be 0 or 1", MASK_INVALID);
  end

  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0] stage_valid;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      dff_stage #(.WIDTH(WIDTH)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .flush   (flush),
        .d       (d),
        .d_valid (d_valid),
        .q       (stage_data[i]),
        .q_valid (stage_valid[i])
      );
    end else begin : g_body
      dff_stage #(.WIDTH(WIDTH)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .flush   (flush),
        .d       (stage_data[i-1]),
        .d_valid (stage_valid[i-1]),
        .q       (stage_data[i]),
        .q_valid (stage_valid[i])
      );
    end
  end

  logic [OCC_W-1:0] occ_q, occ_d;

  // The count tracks entries in minus entries out, so it can never leave 0..DEPTH.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (en) begin
      occ_d = occ_q + OCC_W'(d_valid) - OCC_W'(stage_valid[DEPTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;
  assign q_valid   = stage_valid[DEPTH-1];

  if (MASK_INVALID != 0) begin : g_mask
    assign q = stage_valid[DEPTH-1] ? stage_data[DEPTH-1] : '0;
  end else begin : g_raw
    assign q = stage_data[DEPTH-1];
  end

endmodule

// File: tb/tb_dff_delay_line.sv
// tb/tb_dff_delay_line.sv - directed and random checks of dff_delay_line (8x4 masked
// instance plus a 1x1 raw instance) against queue-based reference models
module tb_dff_delay_line;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d = '0;
  logic       d_valid = 1'b0, en = 1'b0, flush = 1'b0;
  logic [7:0] q;
  logic       q_valid;
  logic [2:0] occupancy;

  logic       s_d = 1'b0, s_d_valid = 1'b1, s_en = 1'b1, s_flush = 1'b0;
  logic       s_q, s_q_valid;
  logic [0:0] s_occupancy;

  int n_cmp = 0;
  int n_bad = 0;
  bit random_phase = 1'b0;
  bit started = 1'b0;
  bit done = 1'b0;

  always #5 clk = ~clk;

  dff_delay_line #(.WIDTH(8), .DEPTH(4), .MASK_INVALID(1)) u_dut (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .en(en), .flush(flush),
    .q(q), .q_valid(q_valid), .occupancy(occupancy)
  );

  dff_delay_line #(.WIDTH(1), .DEPTH(1), .MASK_INVALID(0)) u_small (
    .clk(clk), .rst(rst), .d(s_d), .d_valid(s_d_valid), .en(s_en), .flush(s_flush),
    .q(s_q), .q_valid(s_q_valid), .occupancy(s_occupancy)
  );

  typedef struct packed {
    logic       v;
    logic [7:0] data;
  } ent_t;

  ent_t line[$];
  ent_t small_line[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int count_valid(input ent_t l[$]);
    int c = 0;
    foreach (l[i]) if (l[i].v) c++;
    return c;
  endfunction

  // Reference: the line is a fixed-length queue; an advance pushes the new sample
  // in at the front and drops the oldest one off the back.
  always @(posedge clk) begin
    if (rst) begin
      line = {};
      small_line = {};
      repeat (4) line.push_back('0);
      small_line.push_back('0);
      started = 1'b1;
    end else if (started) begin
      if (flush) foreach (line[i]) line[i].v = 1'b0;
      else if (en) begin
        line.push_front({d_valid, d});
        void'(line.pop_back());
      end
      if (s_flush) small_line[0].v = 1'b0;
      else if (s_en) begin
        small_line.push_front({s_d_valid, 7'b0, s_d});
        void'(small_line.pop_back());
      end
    end
  end

  always @(negedge clk) begin
    if (started && !done) begin
      check("model_q",       {24'b0, q},  line[3].v ? {24'b0, line[3].data} : 32'b0);
      check("model_q_valid", {31'b0, q_valid}, {31'b0, line[3].v});
      check("model_occ",     {29'b0, occupancy}, count_valid(line));
      check("small_q",       {31'b0, s_q}, {31'b0, small_line[0].data[0]});
      check("small_q_valid", {31'b0, s_q_valid}, {31'b0, small_line[0].v});
      check("small_occ",     {31'b0, s_occupancy}, {31'b0, small_line[0].v});
    end
  end

  // Small instance: d toggles every two clocks in the directed phase, random later.
  initial begin
    int k = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!random_phase) begin
        k++;
        s_d = k[1];
      end else begin
        s_d       = 1'($urandom);
        s_d_valid = ($urandom_range(0, 3) != 0);
        s_en      = ($urandom_range(0, 3) != 0);
        s_flush   = ($urandom_range(0, 19) == 0);
      end
    end
  end

  task automatic step(input logic [7:0] dd, input logic dv, input logic e,
                      input logic f, input logic r);
    d = dd; d_valid = dv; en = e; flush = f; rst = r;
    @(posedge clk);
    #2;
  endtask

  task automatic expect_out(input string name, input logic [7:0] eq,
                            input logic eqv, input logic [2:0] eocc);
    check({name, "_q"}, {24'b0, q}, {24'b0, eq});
    check({name, "_qv"}, {31'b0, q_valid}, {31'b0, eqv});
    check({name, "_occ"}, {29'b0, occupancy}, {29'b0, eocc});
  endtask

  initial begin
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("reset", 8'h00, 1'b0, 3'd0);
    check("reset_small_q", {31'b0, s_q}, 32'd0);

    // Single sample 0xA5 on edge 1, visible after edge 4, gone after edge 5.
    step(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_out("single_e1", 8'h00, 1'b0, 3'd1);
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("single_e2", 8'h00, 1'b0, 3'd1);
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("single_e3", 8'h00, 1'b0, 3'd1);
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("single_e4", 8'hA5, 1'b1, 3'd1);
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("single_e5", 8'h00, 1'b0, 3'd0);

    // Stream 1..6: occupancy saturates at 4, q returns values four edges late.
    for (int k = 1; k <= 10; k++) begin
      int acc, gone;
      logic vq;
      step((k <= 6) ? 8'(k) : 8'h00, (k <= 6), 1'b1, 1'b0, 1'b0);
      acc  = (k < 6) ? k : 6;
      gone = (k - 4 < 0) ? 0 : ((k - 4 > 6) ? 6 : k - 4);
      vq   = (k >= 4 && k <= 9);
      expect_out($sformatf("stream_e%0d", k), vq ? 8'(k - 3) : 8'h00, vq, 3'(acc - gone));
    end

    // Two samples in flight, three frozen edges, then resume: latency grows by 3.
    step(8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
    step(8'h22, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
      expect_out($sformatf("freeze_%0d", k), 8'h00, 1'b0, 3'd2);
    end
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("resume_e6", 8'h00, 1'b0, 3'd2);
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("resume_e7", 8'h11, 1'b1, 3'd2);
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("resume_e8", 8'h22, 1'b1, 3'd1);
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("resume_e9", 8'h00, 1'b0, 3'd0);

    // Flush with a valid input while three samples are in flight.
    step(8'h31, 1'b1, 1'b1, 1'b0, 1'b0);
    step(8'h32, 1'b1, 1'b1, 1'b0, 1'b0);
    step(8'h33, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_out("preflush", 8'h00, 1'b0, 3'd3);
    step(8'h99, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_out("flush", 8'h00, 1'b0, 3'd0);
    for (int k = 1; k <= 4; k++) begin
      step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_out($sformatf("postflush_%0d", k), 8'h00, 1'b0, 3'd0);
    end

    // Reset mid-stream, taking priority over a valid input and a flush.
    step(8'h41, 1'b1, 1'b1, 1'b0, 1'b0);
    step(8'h42, 1'b1, 1'b1, 1'b0, 1'b0);
    step(8'h43, 1'b1, 1'b1, 1'b1, 1'b1);
    expect_out("midrst", 8'h00, 1'b0, 3'd0);
    step(8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_out("postrst_e1", 8'h00, 1'b0, 3'd1);
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("postrst_e3", 8'h00, 1'b0, 3'd1);
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("postrst_e4", 8'h55, 1'b1, 3'd1);

    random_phase = 1'b1;
    for (int k = 0; k < 600; k++) begin
      step(8'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 24) == 0), ($urandom_range(0, 59) == 0));
    end

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
